alu_mul_sequencer: RTL and testbench

- Initiator-side controller for the 8-bit combinational adder ALU (ports a, b, m -> out; out = a+b mod 256 when m=1, else 0).
- Accepts an operand pair over a valid/ready handshake and computes the low 8 bits of x*y by shift-and-add. Each step drives the ALU externally.
- Returns the product over a second valid/ready handshake.
- Sits between the datapath control logic and the existing ALU instance; it adds no arithmetic of its own.

---
 rtl/alu_mul_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_alu_mul_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer
//
// Initiator-side controller for the shared 8-bit adder ALU. It accepts an
// operand pair (x, y) over a valid/ready handshake and computes the low
// 8 bits of x*y by shift-and-add. Every add is done by the external ALU
// through alu_a/alu_b/alu_m. The product is returned over a second
// valid/ready handshake. The block has no adder of its own.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   synchronous, active-high reset
//   start_valid  in   operand pair x/y is valid
//   start_ready  out  block can accept operands (IDLE only)
//   x            in   [7:0] multiplicand
//   y            in   [7:0] multiplier
//   alu_a        out  [7:0] ALU operand a (accumulator during RUN)
//   alu_b        out  [7:0] ALU operand b (shifted multiplicand during RUN)
//   alu_m        out  ALU mode, 1 = add, 0 = output zero
//   alu_out      in   [7:0] ALU result, combinational from alu_a/alu_b/alu_m
//   res_valid    out  product is valid
//   res_ready    in   consumer accepts product
//   product      out  [7:0] (x*y) mod 256
//
// Timing: start accepted at edge T, RUN for 8 cycles, res_valid high from
// cycle T+9. With res_ready held high, one product every 10 cycles.
//
// Optional build macro ALU_MUL_ZERO_SKIP_EN: RUN also ends as soon as the
// multiplier has no set bits left above the one being consumed. Results are
// unchanged; only the latency shrinks.

module alu_mul_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_valid,
  output logic       start_ready,
  input  logic [7:0] x,
  input  logic [7:0] y,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic       alu_m,
  input  logic [7:0] alu_out,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] product
);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] mcand_q, mcand_d;
  logic [7:0] mplier_q, mplier_d;
  logic [7:0] acc_q, acc_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] product_q, product_d;
  logic       res_valid_q, res_valid_d;

  // Accumulator value after the current RUN step.
  logic [7:0] acc_step;
  // Current RUN step is the last one.
  logic       run_last;

  // ---------------------------------------------------------------------
  // Outputs: decoded from registered state only. Reset forces the
  // handshake-ready and ALU drive low in the same cycle it is asserted.
  // ---------------------------------------------------------------------
  always_comb begin
    start_ready = 1'b0;
    alu_a       = 8'h00;
    alu_b       = 8'h00;
    alu_m       = 1'b0;
    if (!reset) begin
      unique case (state_q)
        StIdle: begin
          start_ready = 1'b1;
        end
        StRun: begin
          alu_a = acc_q;
          alu_b = mcand_q;
          alu_m = mplier_q[0];
        end
        StDone: begin
          start_ready = 1'b0;
        end
        default: begin
          start_ready = 1'b0;
        end
      endcase
    end
  end

  assign res_valid = res_valid_q;
  assign product   = product_q;

  // ALU yields zero when m=0, so the accumulator must be held explicitly
  // rather than taking alu_out unconditionally.
  assign acc_step = mplier_q[0] ? alu_out : acc_q;

`ifdef ALU_MUL_ZERO_SKIP_EN
  // Once the remaining multiplier bits above bit 0 are all zero, every
  // further step would hold acc, so stop early.
  assign run_last = (cnt_q == 3'd7) || (mplier_q[7:1] == 7'd0);
`else
  assign run_last = (cnt_q == 3'd7);
`endif

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    product_d   = product_q;
    res_valid_d = res_valid_q;

    unique case (state_q)
      StIdle: begin
        if (start_valid) begin
          mcand_d  = x;
          mplier_d = y;
          acc_d    = 8'h00;
          cnt_d    = 3'd0;
          state_d  = StRun;
        end
      end

      StRun: begin
        acc_d    = acc_step;
        // Bits shifted past bit 7 are dropped: arithmetic is mod 256.
        mcand_d  = {mcand_q[6:0], 1'b0};
        mplier_d = {1'b0, mplier_q[7:1]};
        cnt_d    = cnt_q + 3'd1;
        if (run_last) begin
          // Capture the freshly computed accumulator, not the old one.
          product_d   = acc_step;
          res_valid_d = 1'b1;
          state_d     = StDone;
        end
      end

      StDone: begin
        // product/res_valid hold until the consumer takes the result; no
        // new start is accepted here.
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end

      default: begin
        state_d     = StIdle;
        res_valid_d = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // State registers, synchronous reset. Reset mid-operation discards the
  // in-flight operands and produces no result.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      mcand_q     <= 8'h00;
      mplier_q    <= 8'h00;
      acc_q       <= 8'h00;
      cnt_q       <= 3'd0;
      product_q   <= 8'h00;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      product_q   <= product_d;
      res_valid_q <= res_valid_d;
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed testbench for alu_mul_sequencer. Models the external adder ALU
// and checks products, latency, ALU drive, backpressure and reset abort.
// Inputs change on the falling edge; outputs are sampled on the falling edge.

module tb_alu_mul_sequencer;

  logic       clk;
  logic       reset;
  logic       start_valid;
  logic       start_ready;
  logic [7:0] x;
  logic [7:0] y;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic       alu_m;
  logic [7:0] alu_out;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] product;

  int errors = 0;
  int checks = 0;

`ifdef ALU_MUL_ZERO_SKIP_EN
  localparam int LatY3 = 2;
  localparam int LatY0 = 1;
`else
  localparam int LatY3 = 8;
  localparam int LatY0 = 8;
`endif

  alu_mul_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .x           (x),
    .y           (y),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_m       (alu_m),
    .alu_out     (alu_out),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .product     (product)
  );

  // The external ALU: a+b mod 256 when m=1, else zero.
  assign alu_out = alu_m ? 8'(alu_a + alu_b) : 8'h00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1, "timeout");
  end

  // Starts one operation from a falling edge in IDLE and returns at the falling
  // edge where res_valid is first seen high. lat counts rising edges after the
  // accepting edge; mseq records alu_m on each RUN cycle.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, output logic [7:0] p,
                        output int lat, output logic [7:0] mseq, output int runs,
                        output bit ok);
    ok   = 1'b1;
    lat  = 0;
    runs = 0;
    mseq = 8'h00;
    x = a;
    y = b;
    start_valid = 1'b1;
    for (int i = 0; i < 30 && !start_ready; i++) @(negedge clk);
    if (!start_ready) ok = 1'b0;
    @(posedge clk);
    #1 start_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (res_valid) break;
      if (runs < 8) mseq[runs] = alu_m;
      runs++;
      @(posedge clk);
      lat++;
    end
    if (!res_valid) ok = 1'b0;
    p = product;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start_valid = 1'b0;
    res_ready = 1'b1;
    x = 8'h00;
    y = 8'h00;
    repeat (3) @(negedge clk);
    checks++; if (start_ready !== 1'b0) begin errors++; $display("FAIL reset_start_ready: got %b want 0", start_ready); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
    checks++; if (product !== 8'h00) begin errors++; $display("FAIL reset_product: got %h want 00", product); end
    checks++; if ({alu_a, alu_b, alu_m} !== 17'h0) begin errors++; $display("FAIL reset_alu: got a=%h b=%h m=%b want 0", alu_a, alu_b, alu_m); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL idle_start_ready: got %b want 1", start_ready); end
  endtask

  task automatic test_basic();
    logic [7:0] p, mseq;
    int lat, runs;
    bit ok;
    res_ready = 1'b1;
    run_op(8'd5, 8'd3, p, lat, mseq, runs, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL basic_handshake: got ok=%b want 1", ok); end
    checks++; if (p !== 8'h0F) begin errors++; $display("FAIL basic_product: got %h want 0f", p); end
    checks++; if (lat !== LatY3) begin errors++; $display("FAIL basic_latency: got %0d want %0d", lat, LatY3); end
    checks++; if (runs !== LatY3) begin errors++; $display("FAIL basic_run_cycles: got %0d want %0d", runs, LatY3); end
    checks++; if (mseq !== 8'b0000_0011) begin errors++; $display("FAIL basic_alu_m_seq: got %b want 00000011", mseq); end
    checks++; if (start_ready !== 1'b0) begin errors++; $display("FAIL basic_done_start_ready: got %b want 0", start_ready); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL basic_res_valid_drop: got %b want 0", res_valid); end
  endtask

  task automatic test_wrap();
    logic [7:0] vx [3] = '{8'h10, 8'hFF, 8'h0F};
    logic [7:0] vy [3] = '{8'h10, 8'hFF, 8'h11};
    logic [7:0] ve [3] = '{8'h00, 8'h01, 8'hFF};
    logic [7:0] p, mseq;
    int lat, runs;
    bit ok;
    res_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run_op(vx[i], vy[i], p, lat, mseq, runs, ok);
      checks++; if (ok !== 1'b1 || p !== ve[i]) begin errors++; $display("FAIL wrap_%0d: got %h (ok=%b) want %h", i, p, ok, ve[i]); end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] p, mseq;
    int lat, runs;
    bit ok;
    res_ready = 1'b0;
    run_op(8'd7, 8'd9, p, lat, mseq, runs, ok);
    checks++; if (ok !== 1'b1 || p !== 8'h3F) begin errors++; $display("FAIL bp_product: got %h (ok=%b) want 3f", p, ok); end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++; if (res_valid !== 1'b1 || product !== 8'h3F || start_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d: got valid=%b product=%h ready=%b want 1 3f 0", i, res_valid, product, start_ready);
      end
    end
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (res_valid !== 1'b0 || start_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got valid=%b ready=%b want 0 1", res_valid, start_ready); end
    checks++; if (product !== 8'h3F) begin errors++; $display("FAIL bp_product_kept: got %h want 3f", product); end
  endtask

  task automatic test_reset_mid_op();
    logic [7:0] p, mseq;
    int lat, runs;
    bit ok;
    res_ready = 1'b1;
    x = 8'd3;
    y = 8'hFF;
    start_valid = 1'b1;
    @(posedge clk);
    #1 start_valid = 1'b0;
    @(negedge clk);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (res_valid !== 1'b0 || product !== 8'h00) begin errors++; $display("FAIL rst_mid_result: got valid=%b product=%h want 0 00", res_valid, product); end
    checks++; if ({alu_a, alu_b, alu_m} !== 17'h0 || start_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got a=%h b=%h m=%b ready=%b want all 0", alu_a, alu_b, alu_m, start_ready);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (start_ready !== 1'b1 || res_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_idle: got ready=%b valid=%b want 1 0", start_ready, res_valid); end
    run_op(8'd2, 8'd2, p, lat, mseq, runs, ok);
    checks++; if (ok !== 1'b1 || p !== 8'h04) begin errors++; $display("FAIL rst_mid_next: got %h (ok=%b) want 04", p, ok); end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_zero_skip();
    logic [7:0] p, mseq;
    int lat, runs;
    bit ok;
    res_ready = 1'b1;
    run_op(8'hAB, 8'h00, p, lat, mseq, runs, ok);
    checks++; if (ok !== 1'b1 || p !== 8'h00) begin errors++; $display("FAIL zs_y0_product: got %h (ok=%b) want 00", p, ok); end
    checks++; if (lat !== LatY0) begin errors++; $display("FAIL zs_y0_latency: got %0d want %0d", lat, LatY0); end
    @(posedge clk);
    @(negedge clk);
    run_op(8'h01, 8'h80, p, lat, mseq, runs, ok);
    checks++; if (ok !== 1'b1 || p !== 8'h80) begin errors++; $display("FAIL zs_y80_product: got %h (ok=%b) want 80", p, ok); end
    checks++; if (lat !== 8) begin errors++; $display("FAIL zs_y80_latency: got %0d want 8", lat); end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    res_ready = 1'b1;
    checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready0: got %b want 1", start_ready); end
    x = 8'd2;
    y = 8'd3;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    x = 8'd4;
    y = 8'd5;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (res_valid) break;
    end
    checks++; if (res_valid !== 1'b1 || product !== 8'h06) begin errors++; $display("FAIL b2b_first: got valid=%b product=%h want 1 06", res_valid, product); end
    checks++; if (start_ready !== 1'b0) begin errors++; $display("FAIL b2b_done_ready: got %b want 0", start_ready); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (start_ready !== 1'b1 || res_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap: got ready=%b valid=%b want 1 0", start_ready, res_valid); end
    @(posedge clk);
    #1 start_valid = 1'b0;
    @(negedge clk);
    checks++; if (start_ready !== 1'b0) begin errors++; $display("FAIL b2b_second_accept: got ready=%b want 0", start_ready); end
    for (int i = 0; i < 20; i++) begin
      if (res_valid) break;
      @(negedge clk);
    end
    checks++; if (res_valid !== 1'b1 || product !== 8'h14) begin errors++; $display("FAIL b2b_second: got valid=%b product=%h want 1 14", res_valid, product); end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_reset_mid_op();
    test_zero_skip();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
